// File: rtl/div_ctrl.sv
// Multicycle restoring divider for MIPS div/divu: quotient to lo, remainder to hi.
// One quotient bit per clock, then a sign-fix cycle; divide-by-zero exits via ERR.
module div_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_unsigned,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] lo_d, hi_d;
  logic             busy_d, done_d, dz_d;

  // Operand signs and magnitudes; the most negative value maps to itself as unsigned.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_neg = ~is_unsigned & dividend[WIDTH-1];
  assign b_neg = ~is_unsigned & divisor[WIDTH-1];
  assign a_mag = a_neg ? WIDTH'(-dividend) : dividend;
  assign b_mag = b_neg ? WIDTH'(-divisor) : divisor;

  // One restoring step: shift next dividend bit into the WIDTH+1 bit partial remainder.
  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [WIDTH-1:0] rem_sub;
  assign rem_sh  = {r_q, q_q[WIDTH-1]};
  assign ge      = (rem_sh >= {1'b0, d_q});
  assign rem_sub = WIDTH'(rem_sh - {1'b0, d_q});

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    lo_d    = lo;
    hi_d    = hi;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    dz_d    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          if (divisor == '0) begin
            state_d = S_ERR;
            done_d  = 1'b1;
            dz_d    = 1'b1;
          end else begin
            state_d = S_CALC;
            busy_d  = 1'b1;
            q_d     = a_mag;
            d_d     = b_mag;
            r_d     = '0;
            cnt_d   = '0;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
          end
        end
      end
      S_CALC: begin
        busy_d = 1'b1;
        q_d    = {q_q[WIDTH-2:0], ge};
        r_d    = ge ? rem_sub : rem_sh[WIDTH-1:0];
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        lo_d    = qneg_q ? WIDTH'(-q_q) : q_q;
        hi_d    = rneg_q ? WIDTH'(-r_q) : r_q;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      q_q      <= '0;
      r_q      <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      lo       <= '0;
      hi       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      r_q      <= r_d;
      d_q      <= d_d;
      cnt_q    <= cnt_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      lo       <= lo_d;
      hi       <= hi_d;
      busy     <= busy_d;
      done     <= done_d;
      div_zero <= dz_d;
    end
  end

endmodule
